// File: rtl/mem_arbiter.sv
// Shared main-memory arbiter between the I-cache and D-cache miss paths.
// Serialises block fills (pipelined reads) and single-word D-side writes.
module mem_arbiter #(
  parameter int unsigned LAT   = 4,
  parameter int unsigned WORDS = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_req,
  input  logic [15:0]              i_addr,
  input  logic                     d_req,
  input  logic                     d_wr,
  input  logic [15:0]              d_addr,
  input  logic [15:0]              d_wdata,
  output logic                     mem_en,
  output logic                     mem_wr,
  output logic [15:0]              mem_addr,
  output logic [15:0]              mem_wdata,
  input  logic [15:0]              mem_rdata,
  input  logic                     mem_rvalid,
  output logic [15:0]              fill_data,
  output logic [$clog2(WORDS)-1:0] fill_word,
  output logic                     i_fill_valid,
  output logic                     d_fill_valid,
  output logic                     i_done,
  output logic                     d_done,
  output logic                     busy
);

  localparam int unsigned WW = $clog2(WORDS);
  localparam int unsigned CW = WW + 1;
  localparam logic [15:0] OFFS_MASK = 16'(2 * WORDS - 1);

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;
  typedef enum logic {SIDE_I, SIDE_D} side_t;

  // Elaboration-time guard on the block geometry and memory latency.
  if (LAT < 1 || WORDS < 2 || (WORDS & (WORDS - 1)) != 0) begin : gBadParams
    $error("mem_arbiter: WORDS must be a power of two >= 2 and LAT >= 1");
  end

  state_t         state, stateNxt;
  side_t          owner, ownerNxt;
  side_t          last, lastNxt;
  logic [15:0]    base, baseNxt;
  logic [15:0]    wdata, wdataNxt;
  logic [CW-1:0]  issCnt, issCntNxt;
  logic [WW-1:0]  rcvCnt, rcvCntNxt;
  logic           grantD;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      owner  <= SIDE_I;
      last   <= SIDE_I;
      base   <= '0;
      wdata  <= '0;
      issCnt <= '0;
      rcvCnt <= '0;
    end else begin
      state  <= stateNxt;
      owner  <= ownerNxt;
      last   <= lastNxt;
      base   <= baseNxt;
      wdata  <= wdataNxt;
      issCnt <= issCntNxt;
      rcvCnt <= rcvCntNxt;
    end
  end

  always_comb begin
    stateNxt     = state;
    ownerNxt     = owner;
    lastNxt      = last;
    baseNxt      = base;
    wdataNxt     = wdata;
    issCntNxt    = issCnt;
    rcvCntNxt    = rcvCnt;
    grantD       = 1'b0;
    mem_en       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    fill_data    = '0;
    fill_word    = rcvCnt;
    i_fill_valid = 1'b0;
    d_fill_valid = 1'b0;
    i_done       = 1'b0;
    d_done       = 1'b0;
    busy         = (state != IDLE);

    case (state)
      IDLE: begin
        // On contention the side not granted last time wins.
        grantD    = d_req && (!i_req || last == SIDE_I);
        issCntNxt = '0;
        rcvCntNxt = '0;
        if (grantD) begin
          ownerNxt = SIDE_D;
          lastNxt  = SIDE_D;
          if (d_wr) begin
            stateNxt = WRITE;
            baseNxt  = d_addr;
            wdataNxt = d_wdata;
          end else begin
            stateNxt = FILL;
            baseNxt  = d_addr & ~OFFS_MASK;
          end
        end else if (i_req) begin
          ownerNxt = SIDE_I;
          lastNxt  = SIDE_I;
          stateNxt = FILL;
          baseNxt  = i_addr & ~OFFS_MASK;
        end
      end

      FILL: begin
        if (issCnt != CW'(WORDS)) begin
          mem_en    = 1'b1;
          mem_addr  = base + 16'({issCnt[WW-1:0], 1'b0});
          issCntNxt = issCnt + CW'(1);
        end
        // Returns arrive in issue order; rcvCnt is the word index.
        if (mem_rvalid) begin
          fill_data = mem_rdata;
          if (owner == SIDE_I) i_fill_valid = 1'b1;
          else                 d_fill_valid = 1'b1;
          if (rcvCnt == WW'(WORDS - 1)) begin
            if (owner == SIDE_I) i_done = 1'b1;
            else                 d_done = 1'b1;
            stateNxt  = IDLE;
            rcvCntNxt = '0;
            issCntNxt = '0;
          end else begin
            rcvCntNxt = rcvCnt + WW'(1);
          end
        end
      end

      WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = base;
        mem_wdata = wdata;
        d_done    = 1'b1;
        stateNxt  = IDLE;
      end

      default: stateNxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: per-cycle comparison against a service-level schedule
// model, with a fixed-latency memory and reactive requesters.
module tb_mem_arbiter;

  localparam int unsigned LAT   = 4;
  localparam int unsigned WORDS = 8;
  localparam int unsigned WW    = $clog2(WORDS);
  localparam int MAXC = 600;
  localparam int BIG  = 1 << 30;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_req, d_req, d_wr;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic mem_en, mem_wr, mem_rvalid;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, fill_data;
  logic [WW-1:0] fill_word;
  logic i_fill_valid, d_fill_valid, i_done, d_done, busy;

  always #5 clk = ~clk;

  mem_arbiter #(.LAT(LAT), .WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .fill_data(fill_data), .fill_word(fill_word),
    .i_fill_valid(i_fill_valid), .d_fill_valid(d_fill_valid),
    .i_done(i_done), .d_done(d_done), .busy(busy)
  );

  typedef struct packed {
    logic en; logic wr; logic [15:0] addr; logic [15:0] wdata;
    logic ifv; logic dfv; logic [15:0] fdata; logic [WW-1:0] fword;
    logic idone; logic ddone; logic busy;
  } obs_t;

  typedef struct {
    logic wr; logic [15:0] addr; logic [15:0] data; int start;
  } job_t;

  job_t iJobs[$];
  job_t dJobs[$];
  int   iGrant[16];
  int   dGrant[16];
  obs_t expv[MAXC];
  int   iDoneCyc[$];
  int   dDoneCyc[$];
  logic doneSeq[$];
  int   tests = 0;
  int   fails = 0;

  // Memory: fixed-latency read pipe plus injectable stray valid pulses.
  logic [15:0] memKey;
  logic        stray;
  logic [15:0] strayData;
  logic        pipeV[LAT];
  logic [15:0] pipeA[LAT];

  function automatic logic [15:0] memData(input logic [15:0] a);
    return a ^ memKey;
  endfunction

  always @(posedge clk) begin
    for (int k = LAT - 1; k > 0; k--) begin
      pipeV[k] <= pipeV[k-1];
      pipeA[k] <= pipeA[k-1];
    end
    pipeV[0] <= mem_en && !mem_wr;
    pipeA[0] <= mem_addr;
  end

  assign mem_rvalid = pipeV[LAT-1] | stray;
  assign mem_rdata  = pipeV[LAT-1] ? memData(pipeA[LAT-1]) : strayData;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Service-level schedule: each grant expands into its expected cycle timeline.
  task automatic build_model(output int lastC);
    int ii, di, free, prevI, prevD, avI, avD, g, done, r;
    logic lastD, okI, okD, pickD;
    logic [15:0] blkBase;
    job_t j;
    ii = 0; di = 0; free = 0; prevI = -1; prevD = -1; lastD = 1'b0; lastC = 0;
    foreach (expv[c]) expv[c] = '0;
    while (ii < iJobs.size() || di < dJobs.size()) begin
      avI = (ii < iJobs.size()) ? imax(iJobs[ii].start, prevI + 1) : BIG;
      avD = (di < dJobs.size()) ? imax(dJobs[di].start, prevD + 1) : BIG;
      g = imax(free, (avI < avD) ? avI : avD);
      okI = (avI <= g);
      okD = (avD <= g);
      pickD = okD && (!okI || !lastD);
      j = pickD ? dJobs[di] : iJobs[ii];
      if (pickD && j.wr) begin
        done = g + 1;
        expv[done].en = 1'b1; expv[done].wr = 1'b1;
        expv[done].addr = j.addr; expv[done].wdata = j.data;
        expv[done].ddone = 1'b1; expv[done].busy = 1'b1;
      end else begin
        blkBase = j.addr & ~16'(2 * WORDS - 1);
        for (int k = 0; k < int'(WORDS); k++) begin
          expv[g + 1 + k].en = 1'b1;
          expv[g + 1 + k].addr = blkBase + 16'(2 * k);
          r = g + 1 + k + int'(LAT);
          expv[r].fdata = memData(blkBase + 16'(2 * k));
          expv[r].fword = WW'(k);
          if (pickD) expv[r].dfv = 1'b1; else expv[r].ifv = 1'b1;
        end
        done = g + int'(WORDS) + int'(LAT);
        if (pickD) expv[done].ddone = 1'b1; else expv[done].idone = 1'b1;
        for (int c = g + 1; c <= done; c++) expv[c].busy = 1'b1;
      end
      if (pickD) begin dGrant[di] = g; prevD = done; di++; end
      else begin iGrant[ii] = g; prevI = done; ii++; end
      lastD = pickD;
      free = done + 1;
      lastC = done;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0; stray = 1'b0;
    repeat (LAT + 4) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Drives requesters reactively and compares every cycle against the model.
  task automatic run_sched(input string name, input int abortAt);
    int lastC, nCyc, iIdx, dIdx;
    logic aborted;
    obs_t got;
    logic [WW-1:0] fw;
    iIdx = 0; dIdx = 0;
    build_model(lastC);
    nCyc = (abortAt >= 0) ? abortAt + 12 : lastC + 3;
    if (abortAt >= 0)
      for (int c = abortAt + 1; c < MAXC; c++) expv[c] = '0;
    iDoneCyc.delete(); dDoneCyc.delete(); doneSeq.delete();
    for (int c = 0; c < nCyc; c++) begin
      rst_n = !(abortAt >= 0 && c == abortAt);
      aborted = (abortAt >= 0 && c > abortAt);
      stray = aborted ? 1'($urandom_range(0, 1)) : 1'b0;
      strayData = 16'($urandom);
      if (!aborted && iIdx < iJobs.size() && c >= iJobs[iIdx].start) begin
        i_req = 1'b1;
        i_addr = (c <= iGrant[iIdx]) ? iJobs[iIdx].addr : 16'($urandom);
      end else begin
        i_req = 1'b0;
        i_addr = 16'($urandom);
      end
      if (!aborted && dIdx < dJobs.size() && c >= dJobs[dIdx].start) begin
        d_req = 1'b1;
        d_wr = dJobs[dIdx].wr;
        d_addr = (c <= dGrant[dIdx]) ? dJobs[dIdx].addr : 16'($urandom);
        d_wdata = (c <= dGrant[dIdx]) ? dJobs[dIdx].data : 16'($urandom);
      end else begin
        d_req = 1'b0;
        d_wr = 1'($urandom_range(0, 1));
        d_addr = 16'($urandom);
        d_wdata = 16'($urandom);
      end
      @(negedge clk);
      fw = (expv[c].ifv || expv[c].dfv) ? fill_word : '0;
      got = {mem_en, mem_wr, mem_addr, mem_wdata, i_fill_valid, d_fill_valid,
             fill_data, fw, i_done, d_done, busy};
      tests++;
      if (got !== expv[c]) begin
        fails++;
        $display("FAIL %s cyc %0d: got en=%b wr=%b a=%h wd=%h iv=%b dv=%b fd=%h fw=%0d id=%b dd=%b busy=%b; exp en=%b wr=%b a=%h wd=%h iv=%b dv=%b fd=%h fw=%0d id=%b dd=%b busy=%b",
                 name, c, got.en, got.wr, got.addr, got.wdata, got.ifv, got.dfv, got.fdata,
                 got.fword, got.idone, got.ddone, got.busy,
                 expv[c].en, expv[c].wr, expv[c].addr, expv[c].wdata, expv[c].ifv, expv[c].dfv,
                 expv[c].fdata, expv[c].fword, expv[c].idone, expv[c].ddone, expv[c].busy);
      end
      if (i_done === 1'b1) begin iDoneCyc.push_back(c); doneSeq.push_back(1'b0); iIdx++; end
      if (d_done === 1'b1) begin dDoneCyc.push_back(c); doneSeq.push_back(1'b1); dIdx++; end
      @(posedge clk);
      #1;
    end
    if (abortAt < 0) begin
      tests++;
      if (iIdx != iJobs.size() || dIdx != dJobs.size()) begin
        fails++;
        $display("FAIL %s jobs_done: got i=%0d d=%0d, expected i=%0d d=%0d",
                 name, iIdx, dIdx, iJobs.size(), dJobs.size());
      end
    end
    rst_n = 1'b1; i_req = 1'b0; d_req = 1'b0; stray = 1'b0;
  endtask

  task automatic check_cyc(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic clear_jobs();
    iJobs.delete();
    dJobs.delete();
  endtask

  task automatic test_reset();
    logic [58:0] got;
    @(posedge clk);
    #1;
    for (int c = 0; c < 6; c++) begin
      i_req = 1'($urandom_range(0, 1)); d_req = 1'($urandom_range(0, 1));
      d_wr = 1'($urandom_range(0, 1));
      i_addr = 16'($urandom); d_addr = 16'($urandom); d_wdata = 16'($urandom);
      stray = 1'($urandom_range(0, 1)); strayData = 16'($urandom);
      @(negedge clk);
      got = {mem_en, mem_wr, mem_addr, mem_wdata, i_fill_valid, d_fill_valid,
             fill_data, fill_word, i_done, d_done, busy, 1'b0};
      tests++;
      if (got !== '0) begin
        fails++;
        $display("FAIL reset_outputs cyc %0d: got %h, expected all zero", c, got);
      end
      @(posedge clk);
      #1;
    end
    stray = 1'b0;
  endtask

  task automatic test_i_fill();
    clear_jobs();
    iJobs.push_back('{1'b0, 16'h0046, 16'h0000, 0});
    do_reset();
    run_sched("i_fill", -1);
    check_cyc("i_fill_done_count", iDoneCyc.size(), 1);
    if (iDoneCyc.size() > 0) check_cyc("i_fill_done_cycle", iDoneCyc[0], 12);
  endtask

  task automatic test_contention();
    clear_jobs();
    iJobs.push_back('{1'b0, 16'h0123, 16'h0000, 0});
    dJobs.push_back('{1'b0, 16'h3456, 16'h0000, 0});
    do_reset();
    run_sched("contention", -1);
    if (dDoneCyc.size() > 0) check_cyc("contention_d_done", dDoneCyc[0], 12);
    else check_cyc("contention_d_done_count", 0, 1);
    if (iDoneCyc.size() > 0) check_cyc("contention_i_done", iDoneCyc[0], 25);
    else check_cyc("contention_i_done_count", 0, 1);
  endtask

  task automatic test_write();
    clear_jobs();
    dJobs.push_back('{1'b1, 16'h1234, 16'hBEEF, 0});
    do_reset();
    run_sched("d_write", -1);
    if (dDoneCyc.size() > 0) check_cyc("d_write_done_cycle", dDoneCyc[0], 1);
    else check_cyc("d_write_done_count", 0, 1);
  endtask

  task automatic test_addr_edge();
    clear_jobs();
    dJobs.push_back('{1'b0, 16'hFFF6, 16'h0000, 0});
    do_reset();
    run_sched("addr_edge", -1);
  endtask

  task automatic test_back_to_back();
    clear_jobs();
    dJobs.push_back('{1'b1, 16'h0A0A, 16'h5A5A, 0});
    dJobs.push_back('{1'b0, 16'h2222, 16'h0000, 0});
    iJobs.push_back('{1'b0, 16'h7778, 16'h0000, 1});
    do_reset();
    run_sched("back_to_back", -1);
    if (iDoneCyc.size() > 0) check_cyc("b2b_i_done_cycle", iDoneCyc[0], 14);
    else check_cyc("b2b_i_done_count", 0, 1);
  endtask

  task automatic test_round_robin();
    clear_jobs();
    for (int k = 0; k < 4; k++) begin
      iJobs.push_back('{1'b0, 16'($urandom), 16'h0000, 0});
      dJobs.push_back('{1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 0});
    end
    do_reset();
    run_sched("round_robin", -1);
    check_cyc("rr_service_count", doneSeq.size(), 8);
    for (int k = 0; k < doneSeq.size(); k++)
      check_cyc("rr_order_is_d", int'(doneSeq[k]), (k % 2 == 0) ? 1 : 0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      clear_jobs();
      for (int k = 0; k < int'($urandom_range(1, 3)); k++)
        iJobs.push_back('{1'b0, 16'($urandom), 16'h0000, int'($urandom_range(0, 25))});
      for (int k = 0; k < int'($urandom_range(1, 3)); k++)
        dJobs.push_back('{1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                          int'($urandom_range(0, 25))});
      do_reset();
      run_sched("random", -1);
    end
  endtask

  task automatic test_reset_abort();
    clear_jobs();
    iJobs.push_back('{1'b0, 16'h0046, 16'h0000, 0});
    do_reset();
    run_sched("reset_abort", 6);
    check_cyc("abort_no_i_done", iDoneCyc.size(), 0);
  endtask

  initial begin
    memKey = 16'($urandom);
    stray = 1'b0; strayData = '0;
    i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    test_reset();
    test_i_fill();
    test_contention();
    test_write();
    test_addr_edge();
    test_back_to_back();
    test_round_robin();
    test_random();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
